// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit seven-segment scan controller with per-slot dead time and per-digit blanking
module seg_scan_ctrl #(
  parameter int CLK_DIV          = 4,
  parameter int BLANK_CYCLES     = 1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] blank_mask_i,
  output logic [2:0] Sel,
  output logic [7:0] Digit_en_o,
  output logic       Blank_o,
  output logic       Frame_done_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] BL = DW'(BLANK_CYCLES);
  localparam logic [7:0] OFF = {8{DIGIT_ACTIVE_LOW}};
  logic [DW-1:0] div_cnt, div_nxt;
  logic [2:0] sel_nxt;
  logic mask_q, mask_nxt, wrap, drive;
  // outputs are derived from next-state values so the enables always match the registered Sel
  always_comb begin
    wrap     = en_i && div_cnt == LAST;
    div_nxt  = wrap ? '0 : div_cnt + DW'(en_i);
    sel_nxt  = Sel + 3'(wrap);
    mask_nxt = div_nxt == '0 ? blank_mask_i[sel_nxt] : mask_q;
    drive    = en_i && div_nxt >= BL && !mask_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      Sel          <= '0;
      mask_q       <= blank_mask_i[0];
      Digit_en_o   <= OFF;
      Blank_o      <= 1'b1;
      Frame_done_o <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      Sel          <= sel_nxt;
      mask_q       <= mask_nxt;
      Digit_en_o   <= drive ? (8'b1 << sel_nxt) ^ OFF : OFF;
      Blank_o      <= !drive;
      Frame_done_o <= wrap && sel_nxt == 3'd0;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: two parameterisations checked against a tick-count model plus directed literal checks
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [2:0] a_sel [2];
  logic [7:0] a_den [2];
  logic a_blank [2], a_fd [2];
  int cmp_n = 0, err_n = 0;
  int cd [2] = '{4, 2};
  int bl [2] = '{1, 0};
  bit al [2] = '{1'b1, 1'b0};
  int t [2];
  bit mk [2];
  logic [2:0] e_sel [2];
  logic [7:0] e_den [2];
  logic e_blank [2], e_fd [2];
  bit valid = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1), .DIGIT_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en_i(en), .blank_mask_i(mask),
    .Sel(a_sel[0]), .Digit_en_o(a_den[0]), .Blank_o(a_blank[0]), .Frame_done_o(a_fd[0]));
  seg_scan_ctrl #(.CLK_DIV(2), .BLANK_CYCLES(0), .DIGIT_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en_i(en), .blank_mask_i(mask),
    .Sel(a_sel[1]), .Digit_en_o(a_den[1]), .Blank_o(a_blank[1]), .Frame_done_o(a_fd[1]));

  // model: t counts enabled cycles since reset; slot position follows from plain division
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int tn, d, s;
      bit mn;
      logic [7:0] off;
      off = al[i] ? 8'hFF : 8'h00;
      if (rst) begin
        t[i] <= 0;
        mk[i] <= mask[0];
        e_sel[i] <= 3'd0;
        e_den[i] <= off;
        e_blank[i] <= 1'b1;
        e_fd[i] <= 1'b0;
      end else begin
        tn = en ? t[i] + 1 : t[i];
        d = tn % cd[i];
        s = (tn / cd[i]) % 8;
        mn = d == 0 ? mask[s] : mk[i];
        t[i] <= tn;
        mk[i] <= mn;
        e_sel[i] <= 3'(s);
        if (en && d >= bl[i] && !mn) begin
          e_den[i] <= off ^ (8'h01 << s);
          e_blank[i] <= 1'b0;
        end else begin
          e_den[i] <= off;
          e_blank[i] <= 1'b1;
        end
        e_fd[i] <= en && d == 0 && s == 0;
      end
    end
    if (rst) valid <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] act_bits;
        act_bits = al[i] ? ~a_den[i] : a_den[i];
        chk($sformatf("mdl_sel%0d", i), 32'(a_sel[i]), 32'(e_sel[i]));
        chk($sformatf("mdl_den%0d", i), 32'(a_den[i]), 32'(e_den[i]));
        chk($sformatf("mdl_blank%0d", i), 32'(a_blank[i]), 32'(e_blank[i]));
        chk($sformatf("mdl_fd%0d", i), 32'(a_fd[i]), 32'(e_fd[i]));
        chk($sformatf("onehot%0d", i), 32'($countones(act_bits) <= 1), 32'd1);
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    edges(2);
    chk("rst_sel", 32'(a_sel[0]), 32'd0);
    chk("rst_den", 32'(a_den[0]), 32'hFF);
    chk("rst_blank", 32'(a_blank[0]), 32'd1);
    chk("rst_den1", 32'(a_den[1]), 32'h00);
    rst = 1'b0;
    en = 1'b1;
    edges(1);
    chk("t1_den", 32'(a_den[0]), 32'hFE);
    chk("t1_den1", 32'(a_den[1]), 32'h01);
    edges(1);
    chk("t2_den1", 32'(a_den[1]), 32'h02);
    edges(2);
    chk("t4_sel", 32'(a_sel[0]), 32'd1);
    chk("t4_den", 32'(a_den[0]), 32'hFF);
    edges(1);
    chk("t5_den", 32'(a_den[0]), 32'hFD);
    edges(23);
    chk("t28_sel", 32'(a_sel[0]), 32'd7);
    edges(1);
    chk("t29_den", 32'(a_den[0]), 32'h7F);
    edges(3);
    chk("t32_sel", 32'(a_sel[0]), 32'd0);
    chk("t32_fd", 32'(a_fd[0]), 32'd1);
    chk("t32_den", 32'(a_den[0]), 32'hFF);
    chk("t32_fd1", 32'(a_fd[1]), 32'd1);
    chk("t32_den1", 32'(a_den[1]), 32'h01);
    edges(1);
    chk("t33_fd", 32'(a_fd[0]), 32'd0);
    mask = 8'h04;
    edges(7);
    chk("mask_sel", 32'(a_sel[0]), 32'd2);
    chk("mask_den", 32'(a_den[0]), 32'hFF);
    chk("mask_blank", 32'(a_blank[0]), 32'd1);
    edges(3);
    chk("mask_den_end", 32'(a_den[0]), 32'hFF);
    mask = 8'h00;
    edges(3);
    chk("t46_sel", 32'(a_sel[0]), 32'd3);
    en = 1'b0;
    edges(5);
    chk("frz_sel", 32'(a_sel[0]), 32'd3);
    chk("frz_den", 32'(a_den[0]), 32'hFF);
    chk("frz_blank", 32'(a_blank[0]), 32'd1);
    chk("frz_fd", 32'(a_fd[0]), 32'd0);
    en = 1'b1;
    edges(1);
    chk("resume_den", 32'(a_den[0]), 32'hF7);
    edges(5);
    chk("t52_sel", 32'(a_sel[0]), 32'd5);
    rst = 1'b1;
    edges(1);
    chk("mrst_sel", 32'(a_sel[0]), 32'd0);
    chk("mrst_den", 32'(a_den[0]), 32'hFF);
    chk("mrst_fd", 32'(a_fd[0]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 6 == 0) mask = 8'($urandom);
      rst = ($urandom % 250) == 0;
      edges(1);
    end
    rst = 1'b0;
    edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
